// File: rtl/vga_sync_gen.sv
// vga_sync_gen: vertical counter, registered sync/video decode with renderer-matching delay,
// and a line-length monitor that gates video_on until the horizontal timebase is verified.
module vga_sync_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_TOTAL    = 800,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_TOTAL    = 525,
    parameter int PIPE_DELAY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_count,
    input  logic       trig_v,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start,
    output logic       locked,
    output logic       lock_err
);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [3:0] IDLE   = 4'b1100;

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t     r_state;
    logic [9:0] r_pix_x, r_v_count, r_len;
    logic       r_locked, r_lock_err;
    logic [3:0] r_stage_b;
    logic [3:0] w_out;
    logic       w_good, w_over;

    assign w_good = trig_v && r_len == H_LAST;
    assign w_over = r_len > H_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_x   <= '0;
            r_v_count <= '0;
            r_len     <= '0;
        end else begin
            r_pix_x <= h_count;
            if (trig_v)
                r_v_count <= (r_v_count == V_LAST) ? '0 : r_v_count + 10'd1;
            r_len <= trig_v ? '0 : r_len + {9'd0, ~&r_len};
        end
    end

    // A pulse arriving together with an overrun is judged as a line, not as a lost timebase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SEARCH;
            r_locked   <= 1'b0;
            r_lock_err <= 1'b0;
        end else begin
            case (r_state)
                SEARCH: if (trig_v) r_state <= MEASURE;
                MEASURE: begin
                    if (w_good) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                    end else if (!trig_v && w_over) begin
                        r_state <= SEARCH;
                    end
                end
                LOCKED: begin
                    if ((trig_v && !w_good) || (!trig_v && w_over)) begin
                        r_state    <= trig_v ? MEASURE : SEARCH;
                        r_locked   <= 1'b0;
                        r_lock_err <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stage_b <= IDLE;
        else
            r_stage_b <= {!(r_pix_x >= HS_BEG && r_pix_x < HS_END),
                          !(r_v_count >= VS_BEG && r_v_count < VS_END),
                          r_pix_x < H_ACT && r_v_count < V_ACT && r_locked,
                          r_pix_x == '0 && r_v_count == '0};
    end

    generate
        if (PIPE_DELAY == 0) begin : g_nodly
            assign w_out = r_stage_b;
        end else begin : g_dly
            logic [3:0] r_dly [PIPE_DELAY];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DELAY; i++) r_dly[i] <= IDLE;
                end else begin
                    r_dly[0] <= r_stage_b;
                    for (int i = 1; i < PIPE_DELAY; i++) r_dly[i] <= r_dly[i-1];
                end
            end
            assign w_out = r_dly[PIPE_DELAY-1];
        end
    endgenerate

    assign pix_x       = r_pix_x;
    assign pix_y       = r_v_count;
    assign v_count     = r_v_count;
    assign hsync       = w_out[3];
    assign vsync       = w_out[2];
    assign video_on    = w_out[1];
    assign frame_start = w_out[0];
    assign locked      = r_locked;
    assign lock_err    = r_lock_err;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed lines of 800 pixels against a 12-line frame (V 6/2/2/2),
// checking lock, sync windows, video gating, frame wrap, short line, missing pulse and reset.
module tb_vga_sync_gen;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] h_count;
    logic       trig_v;
    logic [9:0] pix_x, pix_y, v_count;
    logic       hsync, vsync, video_on, frame_start, locked, lock_err;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_lo, hs_first, vo_cnt, vo_first, fs_cnt, fs_at, vs_mid;
    int sidx = 0, fs_idx = 0, fs_idx_prev = 0;
    bit lk0, lk1;

    vga_sync_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_TOTAL(800),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_TOTAL(12), .PIPE_DELAY(2)
    ) dut (
        .clk(clk), .rst(rst), .h_count(h_count), .trig_v(trig_v),
        .pix_x(pix_x), .pix_y(pix_y), .v_count(v_count),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .frame_start(frame_start),
        .locked(locked), .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int h, input bit t);
        h_count = 10'(h);
        trig_v  = t;
        @(posedge clk);
        #1;
    endtask

    // Each sample after drive(i) shows the decode of pixel i-3 on the sync outputs.
    task automatic run_line(input int n, input bit t);
        hs_lo = 0; hs_first = -1; vo_cnt = 0; vo_first = -1; fs_cnt = 0; fs_at = -1; vs_mid = -1;
        for (int i = 0; i < n; i++) begin
            drive(i, t && i == 0);
            sidx++;
            if (!hsync) begin hs_lo++; if (hs_first < 0) hs_first = i; end
            if (video_on) begin vo_cnt++; if (vo_first < 0) vo_first = i; end
            if (frame_start) begin fs_cnt++; fs_at = i; fs_idx_prev = fs_idx; fs_idx = sidx; end
            if (i == 0) lk0 = locked;
            if (i == 1) lk1 = locked;
            if (i == 400) vs_mid = vsync;
        end
    endtask

    initial begin
        rst = 1'b1; h_count = '0; trig_v = 1'b0;
        #2;
        check("rst pix_x", pix_x, 0);
        check("rst hsync", hsync, 1);
        check("rst vsync", vsync, 1);
        check("rst locked", locked, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) drive(0, 0);

        run_line(800, 1);
        check("L1 locked end", locked, 0);
        check("L1 video_on", vo_cnt, 0);
        check("L1 hs_lo", hs_lo, 96);
        check("L1 hs_first", hs_first, 659);
        run_line(800, 1);
        check("L2 locked", lk0, 1);
        check("L2 vo_cnt", vo_cnt, 640);
        check("L2 vo_first", vo_first, 3);
        check("L2 v_count", v_count, 2);

        for (int k = 3; k <= 24; k++) begin
            int v;
            v = k % 12;
            run_line(800, 1);
            check($sformatf("k%0d v_count", k), v_count, v);
            check($sformatf("k%0d pix_y", k), pix_y, v);
            check($sformatf("k%0d hs_lo", k), hs_lo, 96);
            check($sformatf("k%0d vsync", k), vs_mid, (v == 8 || v == 9) ? 0 : 1);
            check($sformatf("k%0d vo_cnt", k), vo_cnt, (v < 6) ? 640 : 0);
            check($sformatf("k%0d fs_cnt", k), fs_cnt, (v == 0) ? 1 : 0);
            if (v == 0) check($sformatf("k%0d fs_at", k), fs_at, 3);
        end
        check("frame period", fs_idx - fs_idx_prev, 9600);
        check("pre-short lock_err", lock_err, 0);

        run_line(790, 1);
        check("short locked", locked, 1);
        run_line(800, 1);
        check("after short locked", lk0, 0);
        check("after short lock_err", lock_err, 1);
        check("after short vo_cnt", vo_cnt, 0);
        run_line(800, 1);
        check("relock locked", lk0, 1);
        check("relock lock_err", lock_err, 1);
        check("relock vo_cnt", vo_cnt, 640);

        for (int i = 0; i < 400; i++) drive(i, i == 0);
        check("pre-rst video_on", video_on, 1);
        rst = 1'b1;
        #1;
        check("mid rst pix_x", pix_x, 0);
        check("mid rst v_count", v_count, 0);
        check("mid rst locked", locked, 0);
        check("mid rst lock_err", lock_err, 0);
        check("mid rst hsync", hsync, 1);
        check("mid rst vsync", vsync, 1);
        check("mid rst video_on", video_on, 0);
        check("mid rst frame_start", frame_start, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) drive(0, 0);

        run_line(800, 1);
        check("R1 v_count", v_count, 1);
        run_line(800, 1);
        check("R2 locked", lk0, 1);
        run_line(800, 1);
        run_line(800, 0);
        check("miss locked h0", lk0, 1);
        check("miss locked h1", lk1, 0);
        check("miss lock_err", lock_err, 1);
        check("miss v_count", v_count, 3);
        run_line(800, 1);
        check("R5 locked", lk0, 0);
        check("R5 vo_cnt", vo_cnt, 0);
        run_line(800, 1);
        check("R6 locked", lk0, 1);
        check("R6 vo_cnt", vo_cnt, 640);
        check("R6 v_count", v_count, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Vertical-timing and sync-generation stage that sits directly downstream of the horizontal pixel counter in the VGA display path. It consumes the free-running `h_count` and the once-per-line `trig_v` pulse, and maintains the vertical line counter. It produces registered, pipeline-aligned `hsync`/`vsync`/`video_on`/`frame_start`, and monitors line length to flag a lost or malformed horizontal timebase. Its outputs drive the VGA connector and the tile/pixel renderer.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_TOTAL`, 800, pixels per line; must match the upstream counter period
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_TOTAL`, 525, lines per frame
- `PIPE_DELAY`, 2, extra output delay stages (0..7) to match renderer latency

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  pixel clock (25 MHz nominal)
- `rst`  in  1  asynchronous, active-high reset
- `h_count`  in  10  horizontal position, 0..H_TOTAL-1
- `trig_v`  in  1  one-cycle pulse, high in the same cycle as `h_count`==0
- `pix_x`  out  10  registered copy of `h_count`
- `pix_y` / `v_count`  out  10  vertical line counter, aligned with `pix_x`
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `video_on`  out  1  high in the visible region while locked
- `frame_start`  out  1  one-cycle pulse at pixel (0,0)
- `locked`  out  1  horizontal timebase verified
- `lock_err`  out  1  sticky error; a lock was lost or a bad line was seen after lock

## Operation
- **Stage A (coordinates).**
  - Every cycle, `pix_x` <= `h_count`.
  - When `trig_v`=1, `v_count` <= (`v_count`==V_TOTAL-1) ? 0 : `v_count`+1; otherwise it holds.
  - `pix_x` and `v_count` therefore always form a consistent pair.
- **Stage B (decode), registered from stage A.**
  - hs = !(`pix_x` >= H_ACTIVE+H_FP && `pix_x` < H_ACTIVE+H_FP+H_SYNC).
  - vs = !(`v_count` >= V_ACTIVE+V_FP && `v_count` < V_ACTIVE+V_FP+V_SYNC).
  - vo = `pix_x` < H_ACTIVE && `v_count` < V_ACTIVE && `locked`.
  - fs = `pix_x`==0 && `v_count`==0.
- **Delay line.** A PIPE_DELAY-deep shift register carries hs/vs/vo/fs to the outputs. When PIPE_DELAY=0, the outputs are taken directly from stage B.
- **Line-length monitor.**
  - `len` is a 10-bit counter. On `trig_v` it loads 0; otherwise it increments, saturating at 1023.
  - A line is good when `trig_v` arrives with `len`==H_TOTAL-1.
- **Lock FSM** (states SEARCH, MEASURE, LOCKED):
  - SEARCH: on `trig_v` -> MEASURE.
  - MEASURE: on `trig_v`, stay in MEASURE if the line is bad, go to LOCKED if good. If `len`>H_TOTAL-1 with no `trig_v` -> SEARCH.
  - LOCKED: on `trig_v` with a bad line -> MEASURE and set `lock_err`. If `len`>H_TOTAL-1 -> SEARCH and set `lock_err`.
  - `locked` is 1 only in LOCKED. It is registered, so it is valid the cycle after the transition.
- `lock_err` is cleared only by `rst`.
- Sync outputs keep running while unlocked. Only `video_on` is gated.

## Timing
- Reset values, applied immediately on `rst` assertion:
  - `pix_x`=0, `v_count`=0, `len`=0, state=SEARCH, `locked`=0, `lock_err`=0.
  - `hsync`=1, `vsync`=1, `video_on`=0, `frame_start`=0.
  - All delay-line stages reset to the same idle values.
- Latency from the `h_count` input to `pix_x`/`v_count`: 1 cycle.
- Latency from the `h_count` input to `hsync`/`vsync`/`video_on`/`frame_start`: 2+PIPE_DELAY cycles.
- Lock acquisition: `locked` rises 1 cycle after the second correctly spaced `trig_v`, i.e. at least H_TOTAL+1 cycles after the first one.
- Vertical wrap: `trig_v` while `v_count`=V_TOTAL-1 -> `v_count`=0 on the next cycle. `frame_start` fires 1+PIPE_DELAY cycles later.
- Missing `trig_v`: the FSM leaves LOCKED in the cycle where `len` reaches H_TOTAL. It does not wait for a late pulse.
- `trig_v` coincident with `len` saturation (1023) counts as a bad line.
- `rst` asserted mid-frame: all state returns to reset values at once. After release, the first `trig_v` starts a new measurement and `v_count` resumes from 0.

## Test plan
- **Reset:** assert `rst` mid-line -> all outputs take their reset values asynchronously, before the next clock edge; `lock_err` = 0.
- **Nominal lock:** drive a correct 800-cycle counter -> `locked`=1 one cycle after the 2nd `trig_v`; `video_on`=1 for `pix_x` 0..639 on lines 0..479 only.
- **Sync windows** (PIPE_DELAY=2): `hsync` is low for exactly 96 cycles, starting 4 cycles after `h_count`=656. `vsync` is low for exactly lines 490–491.
- **Frame wrap:** run past line 524 -> `v_count` returns to 0, and `frame_start` pulses once per 420000 cycles.
- **Short line:** while LOCKED, inject a 790-cycle line -> `locked` drops, `lock_err`=1 and stays 1; relock occurs after the next correct line.
- **Missing trig_v:** suppress one pulse -> state=SEARCH when `len`=800, `lock_err`=1, `video_on` held at 0 until relock.
